// File: rtl/logic_arbiter_pkg.sv
// alu_pkg: shared types and constants for the logic arbiter slice.
//   ALU_WIDTH   - default operand/result width of the shared logic unit
//   logic_sel_t - logic unit operation select encoding
//   arb_state_t - arbiter sequencer states
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'd0,
        LOGIC_OR  = 2'd1,
        LOGIC_XOR = 2'd2,
        LOGIC_NOT = 2'd3
    } logic_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/logic_arbiter_if.sv
// logic_arbiter_if: bundles the two request channels, the logic unit
// operand/result bus and the response channel of the arbiter.
//   slave  - arbiter view (drives readies, lu_* operands, response, busy)
//   master - client/datapath view (drives requests, lu_out, rsp_ready)
interface logic_arbiter_if import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_sel;

    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [1:0]       lu_sel;
    logic [WIDTH-1:0] lu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output lu_a, lu_b, lu_sel,
        input  lu_out,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  lu_a, lu_b, lu_sel,
        output lu_out,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/logic_arbiter_rr_grant2.sv
// rr_grant2: combinational two-way round-robin pick.
//   valid0, valid1 - request pending flags
//   last_id        - most recently granted requester
//   gnt_id         - chosen requester
//   gnt_valid      - at least one requester is pending
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_id,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = valid0 | valid1;
        // A tie alternates away from the last winner; a lone requester
        // wins outright (gnt_id = 1 only when requester 1 is the sole one).
        if (valid0 && valid1) begin
            gnt_id = ~last_id;
        end else begin
            gnt_id = valid1;
        end
    end

endmodule

// File: rtl/logic_unit.sv
// logic_unit: shared combinational 8-bit logic datapath.
//   a, b - operands
//   sel  - operation (AND, OR, XOR, NOT A)
//   y    - combinational result
module logic_unit import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (logic_sel_t'(sel))
            LOGIC_AND: y = a & b;
            LOGIC_OR:  y = a | b;
            LOGIC_XOR: y = a ^ b;
            LOGIC_NOT: y = ~a;
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// logic_arbiter: round-robin arbiter/sequencer sharing one logic unit
// between two requesters.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave view of logic_arbiter_if: two valid/ready request
//           channels, registered lu_a/lu_b/lu_sel operands, lu_out result
//           input, valid/ready response channel tagged with rsp_id, busy.
// Flow: IDLE (accept one op) -> EXEC (unit settles, result captured)
//       -> RESP (hold response until rsp_ready) -> IDLE.
module logic_arbiter import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    logic_arbiter_if.slave bus
);

    arb_state_t       state_q;
    arb_state_t       state_d;

    logic             gnt_id;
    logic             gnt_valid;
    logic             offer;
    logic             last_id_q;
    logic             gnt_id_q;

    logic [WIDTH-1:0] lu_a_q;
    logic [WIDTH-1:0] lu_b_q;
    logic [1:0]       lu_sel_q;

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;

    rr_grant2 u_grant (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .last_id   (last_id_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Readiness is offered only in IDLE and is held off while reset is
    // asserted, even though the state register already reads IDLE then.
    assign offer          = rst_n && (state_q == IDLE) && gnt_valid;
    assign bus.req0_ready = offer && !gnt_id;
    assign bus.req1_ready = offer &&  gnt_id;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (offer)         state_d = EXEC;
            EXEC:                    state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            gnt_id_q    <= 1'b0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (offer) begin
                gnt_id_q  <= gnt_id;
                last_id_q <= gnt_id;
                if (gnt_id) begin
                    lu_a_q   <= bus.req1_a;
                    lu_b_q   <= bus.req1_b;
                    lu_sel_q <= bus.req1_sel;
                end else begin
                    lu_a_q   <= bus.req0_a;
                    lu_b_q   <= bus.req0_b;
                    lu_sel_q <= bus.req0_sel;
                end
            end

            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.lu_out;
                rsp_id_q    <= gnt_id_q;
            end else if ((state_q == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.lu_a      = lu_a_q;
    assign bus.lu_b      = lu_b_q;
    assign bus.lu_sel    = lu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Round-robin arbiter and sequencer that shares one 8-bit `logic_unit` between two requesters. It accepts an operation (A, B, select) from one requester at a time through a valid/ready handshake, registers the operands onto the logic unit's inputs, and captures the unit's combinational output. It returns the result on a single response channel tagged with the requester ID. It sits between the instruction-side clients and the shared ALU logic datapath.

## Interface
- `WIDTH`, default 8: operand and result width; matches the logic unit.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` input WIDTH: requester 0 operands.
- `req0_sel` input 2: requester 0 logic select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as requester 0, for requester 1.
- `lu_a`, `lu_b` output WIDTH: registered operands driven to the logic unit.
- `lu_sel` output 2: registered select driven to the logic unit.
- `lu_out` input WIDTH: combinational result from the logic unit.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output WIDTH: captured result.
- `rsp_id` output 1: requester that issued the operation.
- `busy` output 1: high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `reqN_valid` is high, grant one requester.
  - `reqN_ready` is combinational and high only for the granted requester, only in IDLE.
  - On accept (valid && ready): latch a/b/sel into the `lu_*` registers and the ID into `gnt_id`, then go to EXEC.
- **Round-robin:** `last_id` holds the most recently granted requester.
  - When both requesters are valid, grant `~last_id`.
  - When only one is valid, grant it regardless of `last_id`.
  - `last_id` updates on accept.
- **EXEC:** one cycle. `lu_out` settles from the registered inputs. At the clock edge, `rsp_data <= lu_out`, `rsp_id <= gnt_id`, `rsp_valid <= 1`, and the FSM goes to RESP.
- **RESP:** hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - On handshake: `rsp_valid <= 0`, go to IDLE.
  - No new request is accepted in RESP or EXEC; both `reqN_ready` are 0.
- `lu_*` registers keep their last value outside accept; they are not cleared after an operation.
- The arbiter passes `sel` through and never interprets it. The encoding (package constants) is 0 AND, 1 OR, 2 XOR, 3 NOT A.
- **Reset mid-operation:** any in-flight operation is discarded with no response, and FSM returns to IDLE.

## Timing
- Reset values:
  - state IDLE
  - `lu_a`/`lu_b`/`lu_sel` = 0
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0
  - `busy` = 0
  - `last_id` = 1, so requester 0 wins the first tie
- `reqN_ready` is 0 while `rst_n` is low.
- Latency: accept at edge t; `lu_*` valid after t; result registered at t+1; `rsp_valid` high from t+1 to the response handshake.
- Peak throughput: one operation per 3 cycles with `rsp_ready` held high (accept, EXEC, RESP with handshake).
- `rsp_ready` asserted while `rsp_valid` is 0 has no effect.
- `reqN_*` fields are sampled only at accept; changes while `ready` is 0 are ignored.

## Structure
- Package `alu_pkg`:
  - `logic_sel_t` (2-bit) with `LOGIC_AND`/`LOGIC_OR`/`LOGIC_XOR`/`LOGIC_NOT`.
  - `arb_state_t` enum (IDLE, EXEC, RESP).
  - `ALU_WIDTH` = 8.
- Sub-module `rr_grant2`: combinational two-way round-robin pick from (valid0, valid1, last_id), returning grant ID and grant-valid.
- `logic_unit` stays external, connected through the `lu_*` ports; the bench instantiates the real unit.

## Test plan
- **Single request:** req0 A=0x0A, B=0x02, sel=AND, `rsp_ready`=1 → `rsp_valid` at accept+1, `rsp_data`=0x02, `rsp_id`=0, `busy` high for 2 cycles.
- **All selects from requester 1** on A=0x0A, B=0x02, sel 0..3 in sequence → responses 0x02, 0x0A, 0x08, 0xF5, all with `rsp_id`=1, each accept spaced exactly 3 cycles apart.
- **Tie after reset:** both requesters valid continuously (req0 A=0xF6 B=0x0A OR; req1 A=0xF6 B=0x0A XOR) → grants alternate 0, 1, 0, 1; data alternates 0xFE and 0xFC.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → `rsp_data`/`rsp_id` stable, both `reqN_ready`=0 throughout; on `rsp_ready`=1, IDLE is reached on the next edge.
- **Reset in EXEC:** assert `rst_n`=0 one cycle after accept → `rsp_valid` never rises, all outputs at reset values, and the next tie goes to req0.
- **Single-valid override:** `last_id`=1, only req1 valid → req1 is granted immediately.
